// File: rtl/led_blink_scheduler.sv
// Shared-prescaler LED scheduler: N_LEDS channels of OFF/ON/BLINK/ONESHOT driven from one base tick.
// Latency: an accepted config write lands on o_led two edges after acceptance; tick/led/done are registered.
// Backpressure: o_cfg_ready drops for the single APPLY cycle after each accepted write (max 1 write per 2 cycles).
module led_blink_scheduler #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int N_LEDS  = 4,
  parameter int PER_W   = 10
) (
  input  logic              i_clk_100MHz,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [3:0]        i_cfg_ch,
  input  logic [1:0]        i_cfg_mode,
  input  logic [PER_W-1:0]  i_cfg_period,
  output logic              o_cfg_err,
  output logic              o_tick,
  output logic [N_LEDS-1:0] o_led,
  output logic [N_LEDS-1:0] o_done
);

  localparam int            TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int            PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [4:0]    N_LIM    = 5'(N_LEDS);

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_ON      = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  typedef enum logic {S_IDLE, S_APPLY} state_e;

  // Last counter value for a stored period; a stored 0 behaves like 1.
  function automatic logic [PER_W-1:0] last_of(input logic [PER_W-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  state_e           state_q, state_d;
  logic [3:0]       ch_q, ch_d;
  logic [1:0]       wmode_q, wmode_d;
  logic [PER_W-1:0] wper_q, wper_d;
  logic             apply_hit;

  logic [N_LEDS-1:0][1:0]       mode_q, mode_d;
  logic [N_LEDS-1:0][PER_W-1:0] per_q, per_d;
  logic [N_LEDS-1:0][PER_W-1:0] cnt_q, cnt_d;
  logic [N_LEDS-1:0]            led_q, led_d;
  logic [N_LEDS-1:0]            done_q, done_d;

  // Prescaler: free-runs while enabled, tick strobe is the registered wrap event.
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (i_en) begin
      tick_d = (pre_q == PRE_LAST);
      pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  // Config FSM next state: latch the write in IDLE, spend exactly one cycle in APPLY.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wmode_d     = wmode_q;
    wper_d      = wper_q;
    o_cfg_ready = (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_cfg_valid) begin
          ch_d    = i_cfg_ch;
          wmode_d = i_cfg_mode;
          wper_d  = i_cfg_period;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
    apply_hit = (state_q == S_APPLY) && ({1'b0, ch_q} < N_LIM);
    o_cfg_err = (state_q == S_APPLY) && !({1'b0, ch_q} < N_LIM);
  end

  // Channel next state: a write to this channel overrides any tick landing in the same cycle.
  always_comb begin
    mode_d = mode_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    done_d = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (apply_hit && (ch_q == 4'(i))) begin
        mode_d[i] = wmode_q;
        per_d[i]  = wper_q;
        cnt_d[i]  = '0;
        led_d[i]  = (wmode_q != M_OFF);
      end else if (tick_q && (mode_q[i] == M_BLINK || mode_q[i] == M_ONESHOT)) begin
        if (cnt_q[i] == last_of(per_q[i])) begin
          cnt_d[i] = '0;
          if (mode_q[i] == M_BLINK) begin
            led_d[i] = ~led_q[i];
          end else begin
            led_d[i]  = 1'b0;
            mode_d[i] = M_OFF;
            done_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // State registers; reset also drops any write latched but not yet applied.
  always_ff @(posedge i_clk_100MHz or posedge i_clr) begin
    if (i_clr) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      state_q <= S_IDLE;
      ch_q    <= '0;
      wmode_q <= M_OFF;
      wper_q  <= '0;
      mode_q  <= '0;
      per_q   <= {N_LEDS{PER_W'(1)}};
      cnt_q   <= '0;
      led_q   <= '0;
      done_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      wmode_q <= wmode_d;
      wper_q  <= wper_d;
      mode_q  <= mode_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign o_tick = tick_q;
  assign o_led  = led_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: directed scenarios then random config traffic.
// An abstract model predicts per-cycle outputs into a queue; a negedge monitor pops and compares.
module tb_led_blink_scheduler;
  localparam int N   = 4;
  localparam int PW  = 10;
  localparam int DIV = 10;

  logic          clk = 1'b0;
  logic          clr, en, vld, rdy, err, tick;
  logic [3:0]    ch;
  logic [1:0]    mode;
  logic [PW-1:0] per;
  logic [N-1:0]  led, done;

  always #5 clk = ~clk;

  led_blink_scheduler #(.CLK_HZ(100), .TICK_HZ(10), .N_LEDS(N), .PER_W(PW)) dut (
    .i_clk_100MHz(clk), .i_clr(clr), .i_en(en), .i_cfg_valid(vld), .o_cfg_ready(rdy),
    .i_cfg_ch(ch), .i_cfg_mode(mode), .i_cfg_period(per), .o_cfg_err(err),
    .o_tick(tick), .o_led(led), .o_done(done)
  );

  typedef struct packed {
    logic [N-1:0] led;
    logic [N-1:0] done;
    logic         tick;
    logic         rdy;
    logic         err;
  } obs_t;

  localparam obs_t RST_OBS = '{led: '0, done: '0, tick: 1'b0, rdy: 1'b1, err: 1'b0};

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model: ticks counted arithmetically, channel phase from ticks seen since write.
  int m_mode[N];
  int m_p[N];
  int m_n[N];
  bit m_led[N];
  bit m_done[N];
  bit m_tick, m_busy;
  int pend_ch, pend_mode, pend_per;
  int en_cnt;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_mode[c] = 0; m_p[c] = 1; m_n[c] = 0; m_led[c] = 0; m_done[c] = 0;
    end
    m_tick = 0; m_busy = 0; en_cnt = 0;
    pend_ch = 0; pend_mode = 0; pend_per = 0;
  endfunction

  // One rising edge of the model, using the inputs that were held across that edge.
  function automatic void model_edge();
    bit tick_in;
    if (clr) begin
      model_reset();
      return;
    end
    tick_in = m_tick;
    for (int c = 0; c < N; c++) begin
      m_done[c] = 0;
      if (m_busy && pend_ch == c) begin
        m_mode[c] = pend_mode;
        m_p[c]    = (pend_per == 0) ? 1 : pend_per;
        m_n[c]    = 0;
        m_led[c]  = (pend_mode != 0);
      end else if (tick_in && m_mode[c] == 2) begin
        m_n[c]++;
        m_led[c] = ((m_n[c] / m_p[c]) % 2) == 0;
      end else if (tick_in && m_mode[c] == 3) begin
        m_n[c]++;
        if (m_n[c] >= m_p[c]) begin
          m_led[c] = 0; m_mode[c] = 0; m_done[c] = 1;
        end
      end
    end
    if (en) begin
      en_cnt++;
      m_tick = (en_cnt % DIV) == 0;
    end else begin
      m_tick = 0;
    end
    if (m_busy) begin
      m_busy = 0;
    end else if (vld) begin
      m_busy = 1; pend_ch = int'(ch); pend_mode = int'(mode); pend_per = int'(per);
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    for (int c = 0; c < N; c++) begin
      o.led[c]  = m_led[c];
      o.done[c] = m_done[c];
    end
    o.tick = m_tick;
    o.rdy  = !m_busy;
    o.err  = m_busy && (pend_ch >= N);
    return o;
  endfunction

  task automatic cycle(input bit v, input int c, input int md, input int p, input bit e);
    vld = v; ch = 4'(c); mode = 2'(md); per = PW'(p); en = e;
    @(posedge clk);
    #1;
    model_edge();
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic chk(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  // Assert reset between edges and confirm outputs fall back without waiting for a clock.
  task automatic async_clr(input string what);
    #2;
    clr = 1'b1;
    #1;
    chk({what, "_led"},  int'(led),  0);
    chk({what, "_done"}, int'(done), 0);
    chk({what, "_tick"}, int'(tick), 0);
    chk({what, "_err"},  int'(err),  0);
    chk({what, "_rdy"},  int'(rdy),  1);
    idle(2);
    clr = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a new output snapshot, check it against the queue head.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (clr) e = RST_OBS;
        a = '{led: led, done: done, tick: tick, rdy: rdy, err: err};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_obs t=%0t got led=%b done=%b tick=%b rdy=%b err=%b want led=%b done=%b tick=%b rdy=%b err=%b",
                   $time, a.led, a.done, a.tick, a.rdy, a.err, e.led, e.done, e.tick, e.rdy, e.err);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clr = 1'b1; en = 1'b1; vld = 1'b0; ch = '0; mode = '0; per = '0;
    #1;
    chk("reset_led", int'(led), 0);
    chk("reset_rdy", int'(rdy), 1);
    chk("reset_tick", int'(tick), 0);
    idle(3);
    clr = 1'b0;
    idle(25);

    // ch1 blink, half period 3 ticks
    cycle(1'b1, 1, 2, 3, 1'b1);
    idle(100);
    // ch2 oneshot for 2 ticks
    cycle(1'b1, 2, 3, 2, 1'b1);
    idle(40);
    // out-of-range channel: error pulse only
    cycle(1'b1, 7, 1, 1, 1'b1);
    idle(5);
    // ch0 blink with period 0 behaves as 1
    cycle(1'b1, 0, 2, 0, 1'b1);
    idle(30);
    // back-to-back writes with valid held high
    for (int w = 0; w < N; w++) begin
      cycle(1'b1, w, 1, 1, 1'b1);
      cycle(1'b1, w, 1, 1, 1'b1);
    end
    idle(3);
    chk("b2b_all_on", int'(led), 15);

    // freeze the prescaler mid-blink
    cycle(1'b1, 1, 2, 3, 1'b1);
    idle(35);
    repeat (25) cycle(1'b0, 0, 0, 0, 1'b0);
    idle(60);

    // async reset while ch1 LED is lit
    for (int k = 0; k < 100 && led[1] !== 1'b1; k++) idle(1);
    chk("blink_lit_before_clr", int'(led[1]), 1);
    async_clr("clr_blink");
    idle(5);

    // async reset during APPLY: pending write must be dropped
    cycle(1'b1, 3, 1, 1, 1'b1);
    async_clr("clr_apply");
    idle(15);
    chk("apply_dropped", int'(led[3]), 0);

    // random config traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 3,
            ($urandom_range(0, 9) < 8) ? $urandom_range(0, N - 1) : $urandom_range(N, 15),
            $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 19) != 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
